// File: rtl/ppg_window_extractor.sv
`default_nettype none
// ============================================================================
//  Module   : ppg_window_extractor
//  Purpose  : Per-window min/max tracking of RED and IR PPG samples. Once per
//             window of WIN_LEN accepted samples it reports the AC amplitude
//             (max-min), the DC level ((max+min)>>1) and a clip flag for
//             each channel.
//  Options  : PPG_SMOOTH_EN - 4-tap box filter ahead of the trackers with
//             a 3-sample warm-up after each IDLE->ACQ entry.
//  Revision : 1.0  initial release
// ============================================================================
module ppg_window_extractor #(
  parameter int WIN_LEN = 200,
  parameter int CNT_W   = 8
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sample_valid,
  input  logic [7:0] red_sample,
  input  logic [7:0] ir_sample,
  output logic [7:0] red_ac,
  output logic [7:0] red_dc,
  output logic [7:0] ir_ac,
  output logic [7:0] ir_dc,
  output logic [1:0] clip,
  output logic       result_valid,
  output logic       busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACQ  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_LEN - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       red_min_q, red_max_q, ir_min_q, ir_max_q;
  logic             red_clip_q, ir_clip_q;
  logic [7:0]       red_ac_q, red_dc_q, ir_ac_q, ir_dc_q;
  logic [1:0]       clip_q;
  logic             result_valid_q;

  logic             accept;
  logic             track_en;
  logic [7:0]       red_s, ir_s;
  logic [7:0]       red_min_d, red_max_d, ir_min_d, ir_max_d;
  logic             red_clip_d, ir_clip_d;
  logic [8:0]       red_sum_d, ir_sum_d;
  logic             win_end;

  // A pair is taken only while acquiring and still enabled; the pair that
  // coincides with enable falling is dropped.
  assign accept = (state_q == ST_ACQ) && enable && sample_valid;

`ifdef PPG_SMOOTH_EN
  logic [7:0] red_h1_q, red_h2_q, red_h3_q;
  logic [7:0] ir_h1_q, ir_h2_q, ir_h3_q;
  logic [1:0] warm_q;
  logic [9:0] red_fsum, ir_fsum;

  assign red_fsum = {2'b00, red_sample} + {2'b00, red_h1_q} + {2'b00, red_h2_q} + {2'b00, red_h3_q};
  assign ir_fsum  = {2'b00, ir_sample} + {2'b00, ir_h1_q} + {2'b00, ir_h2_q} + {2'b00, ir_h3_q};
  assign red_s    = 8'(red_fsum >> 2);
  assign ir_s     = 8'(ir_fsum >> 2);
  // Only filtered outputs with a full 4-sample history are counted.
  assign track_en = accept && (warm_q == 2'd3);

  // Filter history: cleared while idle, shifted on every accepted pair.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      red_h1_q <= '0; red_h2_q <= '0; red_h3_q <= '0;
      ir_h1_q  <= '0; ir_h2_q  <= '0; ir_h3_q  <= '0;
      warm_q   <= '0;
    end else if (state_q == ST_IDLE) begin
      red_h1_q <= '0; red_h2_q <= '0; red_h3_q <= '0;
      ir_h1_q  <= '0; ir_h2_q  <= '0; ir_h3_q  <= '0;
      warm_q   <= '0;
    end else if (accept) begin
      red_h1_q <= red_sample; red_h2_q <= red_h1_q; red_h3_q <= red_h2_q;
      ir_h1_q  <= ir_sample;  ir_h2_q  <= ir_h1_q;  ir_h3_q  <= ir_h2_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end
`else
  assign red_s    = red_sample;
  assign ir_s     = ir_sample;
  assign track_en = accept;
`endif

  // Tracker next-state including the current sample; clip looks at raw data.
  always_comb begin
    red_min_d  = (red_s < red_min_q) ? red_s : red_min_q;
    red_max_d  = (red_s > red_max_q) ? red_s : red_max_q;
    ir_min_d   = (ir_s < ir_min_q) ? ir_s : ir_min_q;
    ir_max_d   = (ir_s > ir_max_q) ? ir_s : ir_max_q;
    red_clip_d = red_clip_q | (red_sample == 8'd0) | (red_sample == 8'd255);
    ir_clip_d  = ir_clip_q | (ir_sample == 8'd0) | (ir_sample == 8'd255);
    red_sum_d  = {1'b0, red_max_d} + {1'b0, red_min_d};
    ir_sum_d   = {1'b0, ir_max_d} + {1'b0, ir_min_d};
    win_end    = track_en && (cnt_q == LAST_CNT);
  end

  // Control FSM with window trackers and registered result outputs.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      red_min_q      <= 8'hFF; red_max_q <= 8'h00;
      ir_min_q       <= 8'hFF; ir_max_q  <= 8'h00;
      red_clip_q     <= 1'b0;  ir_clip_q <= 1'b0;
      red_ac_q       <= '0; red_dc_q <= '0;
      ir_ac_q        <= '0; ir_dc_q  <= '0;
      clip_q         <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q    <= ST_ACQ;
            cnt_q      <= '0;
            red_min_q  <= 8'hFF; red_max_q <= 8'h00;
            ir_min_q   <= 8'hFF; ir_max_q  <= 8'h00;
            red_clip_q <= 1'b0;  ir_clip_q <= 1'b0;
          end
        end
        ST_ACQ: begin
          if (!enable) begin
            state_q <= ST_IDLE;
          end else if (win_end) begin
            // max >= min always holds, so the subtraction cannot wrap.
            red_ac_q       <= red_max_d - red_min_d;
            red_dc_q       <= red_sum_d[8:1];
            ir_ac_q        <= ir_max_d - ir_min_d;
            ir_dc_q        <= ir_sum_d[8:1];
            clip_q         <= {ir_clip_d, red_clip_d};
            result_valid_q <= 1'b1;
            cnt_q          <= '0;
            red_min_q      <= 8'hFF; red_max_q <= 8'h00;
            ir_min_q       <= 8'hFF; ir_max_q  <= 8'h00;
            red_clip_q     <= 1'b0;  ir_clip_q <= 1'b0;
          end else if (track_en) begin
            cnt_q      <= cnt_q + CNT_W'(1);
            red_min_q  <= red_min_d; red_max_q <= red_max_d;
            ir_min_q   <= ir_min_d;  ir_max_q  <= ir_max_d;
            red_clip_q <= red_clip_d;
            ir_clip_q  <= ir_clip_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign red_ac       = red_ac_q;
  assign red_dc       = red_dc_q;
  assign ir_ac        = ir_ac_q;
  assign ir_dc        = ir_dc_q;
  assign clip         = clip_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q == ST_ACQ);

endmodule
`default_nettype wire

// File: tb/tb_ppg_window_extractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ppg_window_extractor
//  Purpose  : Self-checking bench for ppg_window_extractor (WIN_LEN=8).
//             Expected window results are queued when a window is driven and
//             compared when result_valid pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ppg_window_extractor;

  localparam int WIN = 8;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       sample_valid;
  logic [7:0] red_sample;
  logic [7:0] ir_sample;
  logic [7:0] red_ac, red_dc, ir_ac, ir_dc;
  logic [1:0] clip;
  logic       result_valid;
  logic       busy;

  typedef struct {
    logic [7:0] rac;
    logic [7:0] rdc;
    logic [7:0] iac;
    logic [7:0] idc;
    logic [1:0] clp;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  exp_t e;
  int   pulse_cyc[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic [7:0] wr[WIN];
  logic [7:0] wi[WIN];

  ppg_window_extractor #(.WIN_LEN(WIN), .CNT_W(8)) dut (
    .CLK(CLK), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .red_sample(red_sample), .ir_sample(ir_sample),
    .red_ac(red_ac), .red_dc(red_dc), .ir_ac(ir_ac), .ir_dc(ir_dc),
    .clip(clip), .result_valid(result_valid), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: every result pulse pops and checks one expected window.
  always @(negedge CLK) begin
    if (result_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_pulse: result_valid=1 with no window pending, required 0");
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (red_ac !== e.rac) begin n_bad++; $display("FAIL red_ac: got %0d required %0d", red_ac, e.rac); end
        n_cmp++;
        if (red_dc !== e.rdc) begin n_bad++; $display("FAIL red_dc: got %0d required %0d", red_dc, e.rdc); end
        n_cmp++;
        if (ir_ac !== e.iac) begin n_bad++; $display("FAIL ir_ac: got %0d required %0d", ir_ac, e.iac); end
        n_cmp++;
        if (ir_dc !== e.idc) begin n_bad++; $display("FAIL ir_dc: got %0d required %0d", ir_dc, e.idc); end
        n_cmp++;
        if (clip !== e.clp) begin n_bad++; $display("FAIL clip: got %b required %b", clip, e.clp); end
      end
    end
  end

  // Reference result for the window currently held in wr/wi.
  function automatic exp_t calc();
    exp_t x;
    int rmin = 255, rmax = 0, imin = 255, imax = 0;
    logic rc = 1'b0, ic = 1'b0;
    for (int k = 0; k < WIN; k++) begin
      if (wr[k] < rmin) rmin = wr[k];
      if (wr[k] > rmax) rmax = wr[k];
      if (wi[k] < imin) imin = wi[k];
      if (wi[k] > imax) imax = wi[k];
      if (wr[k] == 0 || wr[k] == 255) rc = 1'b1;
      if (wi[k] == 0 || wi[k] == 255) ic = 1'b1;
    end
    x.rac = 8'(rmax - rmin);
    x.rdc = 8'((rmax + rmin) / 2);
    x.iac = 8'(imax - imin);
    x.idc = 8'((imax + imin) / 2);
    x.clp = {ic, rc};
    return x;
  endfunction

  task automatic drive_pair(input logic [7:0] r, input logic [7:0] i);
    @(posedge CLK); #1;
    sample_valid = 1'b1;
    red_sample   = r;
    ir_sample    = i;
  endtask

  task automatic idle_cycle();
    @(posedge CLK); #1;
    sample_valid = 1'b0;
  endtask

  task automatic send_window();
    last_exp = calc();
    sb.push_back(last_exp);
    for (int k = 0; k < WIN; k++) drive_pair(wr[k], wi[k]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0;
    red_sample = '0; ir_sample = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if ({red_ac, red_dc, ir_ac, ir_dc, clip} !== 34'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h required 0", {red_ac, red_dc, ir_ac, ir_dc, clip});
    end
    n_cmp++;
    if (result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b required 0", result_valid); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    @(posedge CLK); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    enable = 1'b1;
    for (int k = 0; k < WIN; k++) begin wr[k] = 8'(100 + k); wi[k] = 8'd200; end
    send_window();
    idle_cycle();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b required 1", busy); end
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL basic_timeout: pending %0d required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = pulse_cyc.size();
    for (int k = 0; k < WIN; k++) begin wr[k] = 8'(20 + 3 * k); wi[k] = 8'(60 - k); end
    send_window();
    for (int k = 0; k < WIN; k++) begin wr[k] = (k % 2 == 1) ? 8'd150 : 8'd50; wi[k] = 8'd120; end
    send_window();
    idle_cycle();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL b2b_timeout: pending %0d required 0", sb.size()); sb.delete(); end
    n_cmp++;
    if (pulse_cyc.size() != n0 + 2) begin
      n_bad++; $display("FAIL b2b_pulse_count: got %0d required 2", pulse_cyc.size() - n0);
    end else if (pulse_cyc[n0 + 1] - pulse_cyc[n0] != WIN) begin
      n_bad++; $display("FAIL b2b_spacing: got %0d required %0d", pulse_cyc[n0 + 1] - pulse_cyc[n0], WIN);
    end
  endtask

  task automatic test_enable_drop();
    int n0;
    n0 = pulse_cyc.size();
    for (int k = 0; k < 5; k++) drive_pair(8'(1 + k), 8'(250 - k));
    // Sample presented in the same cycle enable falls must be dropped.
    @(posedge CLK); #1;
    enable = 1'b0; sample_valid = 1'b1; red_sample = 8'd0; ir_sample = 8'd255;
    idle_cycle();
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy: got %b required 0", busy); end
    n_cmp++;
    if (pulse_cyc.size() != n0) begin n_bad++; $display("FAIL drop_pulse: got %0d pulses required 0", pulse_cyc.size() - n0); end
    n_cmp++;
    if ({red_ac, red_dc, ir_ac, ir_dc, clip} !== {last_exp.rac, last_exp.rdc, last_exp.iac, last_exp.idc, last_exp.clp}) begin
      n_bad++; $display("FAIL drop_hold: got %h required %h", {red_ac, red_dc, ir_ac, ir_dc, clip},
                        {last_exp.rac, last_exp.rdc, last_exp.iac, last_exp.idc, last_exp.clp});
    end
    @(posedge CLK); #1;
    enable = 1'b1;
    for (int k = 0; k < WIN; k++) begin wr[k] = 8'd10; wi[k] = 8'd10; end
    send_window();
    idle_cycle();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL drop_timeout: pending %0d required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_clip();
    for (int k = 0; k < WIN; k++) begin
      wr[k] = (k == 3) ? 8'd0 : 8'(90 + k);
      wi[k] = (k == 5) ? 8'd255 : 8'd30;
    end
    send_window();
    for (int k = 0; k < WIN; k++) begin wr[k] = 8'(40 + 2 * k); wi[k] = 8'(180 - 5 * k); end
    send_window();
    idle_cycle();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL clip_timeout: pending %0d required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid();
    int n0;
    n0 = pulse_cyc.size();
    for (int k = 0; k < 3; k++) drive_pair(8'd5, 8'd250);
    #2;
    rst_n = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({red_ac, red_dc, ir_ac, ir_dc, clip, result_valid, busy} !== 36'd0) begin
      n_bad++; $display("FAIL midrst_clear: got %h required 0", {red_ac, red_dc, ir_ac, ir_dc, clip, result_valid, busy});
    end
    @(posedge CLK); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) drive_pair(8'd77, 8'd33);
    idle_cycle();
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (pulse_cyc.size() != n0) begin n_bad++; $display("FAIL midrst_pulse: got %0d pulses required 0", pulse_cyc.size() - n0); end
    n_cmp++;
    if ({red_ac, red_dc, ir_ac, ir_dc, clip} !== 34'd0) begin
      n_bad++; $display("FAIL midrst_hold: got %h required 0", {red_ac, red_dc, ir_ac, ir_dc, clip});
    end
  endtask

  task automatic test_smooth();
    int h[3];
    int raw, f, imin, imax, n0;
    exp_t x;
    h = '{0, 0, 0};
    imin = 255; imax = 0;
    for (int n = 0; n < WIN + 3; n++) begin
      raw = (n >= 3) ? 200 : 0;
      f = (raw + h[0] + h[1] + h[2]) / 4;
      h[2] = h[1]; h[1] = h[0]; h[0] = raw;
      if (n >= 3) begin
        if (f < imin) imin = f;
        if (f > imax) imax = f;
      end
    end
    x.rac = 8'd0; x.rdc = 8'd80;
    x.iac = 8'(imax - imin); x.idc = 8'((imax + imin) / 2);
    x.clp = 2'b00;
    sb.push_back(x);
    n0 = pulse_cyc.size();
    enable = 1'b1;
    for (int n = 0; n < WIN + 3; n++) begin
      drive_pair(8'd80, (n >= 3) ? 8'd200 : 8'd0);
      if (n == WIN - 1) begin
        @(negedge CLK);
        n_cmp++;
        if (result_valid !== 1'b0) begin n_bad++; $display("FAIL smooth_early: got %b required 0", result_valid); end
      end
    end
    idle_cycle();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL smooth_timeout: pending %0d required 0", sb.size()); sb.delete(); end
    n_cmp++;
    if (pulse_cyc.size() != n0 + 1) begin n_bad++; $display("FAIL smooth_pulses: got %0d required 1", pulse_cyc.size() - n0); end
  endtask

  initial begin
    test_reset();
`ifdef PPG_SMOOTH_EN
    test_smooth();
`else
    test_basic();
    test_back_to_back();
    test_enable_drop();
    test_clip();
    test_reset_mid();
`endif
    repeat (3) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
